pipe_hold_ctrl: RTL
===================

Name: pipe_hold_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB).
- Generates the hold strobes consumed by every pipeline register, plus a retain (stall) strobe for the PC and IF/ID registers. A pipeline register whose hold is high loads its bubble value, so hold here means "insert bubble".
- Resolves load-use hazards, multi-cycle divide, data-memory wait states and jump redirects, with a fixed priority.
- Keeps a free-running stall-cycle performance counter.

Parameters:
- FLUSH_CYCLES, 1: cycles IF/ID is bubbled after a taken jump. Valid range 1..15.
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before bus error. 0 disables the timeout.
- CNT_W, 32: width of the stall counter.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ex_is_load  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the EX instruction.
- id_rs1, id_rs2  in  5 each  source registers of the ID instruction.
- id_rs1_used, id_rs2_used  in  1 each  source register is actually read.
- jump_req  in  1  taken branch/jump resolved in EX.
- jump_addr  in  32  redirect target.
- mem_req  in  1  MEM stage issues a data access.
- mem_ack  in  1  data memory completes the access.
- div_start  in  1  EX issues a divide.
- div_done  in  1  divider result valid.
- stall_pc  out  1  PC keeps its value.
- stall_if_id  out  1  IF/ID keeps its value.
- hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb  out  1 each  load bubble into the named register.
- jump_en  out  1  PC loads jump_addr_o.
- jump_addr_o  out  32  registered redirect target.
- bus_err  out  1  one-cycle pulse on memory timeout.
- stall_cnt  out  CNT_W  stall cycles counted since reset.

Behaviour:
- Reset: asynchronous, active-low on reset_n, clock clock. While reset_n is low:
  - state = RUN; all counters are 0.
  - jump_en = 0, jump_addr_o = 0, bus_err = 0, stall_cnt = 0.
  - All hold_* outputs are 1 (the whole pipeline is bubbled). All stall_* outputs are 0.
  - Reset mid-operation abandons any wait or flush immediately.
- States: RUN, MEM_WAIT, DIV_WAIT, FLUSH.
- Strobe outputs (stall_*, hold_*) are combinational from state and inputs. jump_en, jump_addr_o and bus_err are registered.
- Load-use hazard (lu): ex_is_load && ex_rd != 0 && ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd)).
- RUN priority, highest first:
  1. mem_req && !mem_ack:
     - Go to MEM_WAIT and clear the timeout counter.
     - stall_pc = stall_if_id = 1; hold_mem_wb = 1.
     - ID/EX and EX/MEM are frozen: their hold stays 0 and their enables are driven externally from stall_if_id.
  2. div_start: go to DIV_WAIT with the same strobes as case 1, except hold_ex_mem = 1 instead of hold_mem_wb.
  3. jump_req:
     - Next cycle: jump_en = 1 and jump_addr_o = jump_addr.
     - Same cycle: hold_if_id = hold_id_ex = 1.
     - If FLUSH_CYCLES > 1, go to FLUSH with counter = FLUSH_CYCLES - 1; otherwise stay in RUN.
     - jump_req has priority over lu (the hazard instruction is flushed anyway).
  4. lu: stall_pc = stall_if_id = 1 and hold_id_ex = 1 for exactly one cycle; stay in RUN.
- Stall accounting: any cycle with stall_pc = 1 increments stall_cnt, which wraps modulo 2^CNT_W.
- MEM_WAIT:
  - Strobes held every cycle.
  - mem_ack returns to RUN in the same cycle; strobes deassert combinationally that cycle.
  - If the counter reaches MEM_TIMEOUT (non-zero): pulse bus_err for one cycle, return to RUN, and assert hold_mem_wb for the abandoned access.
- DIV_WAIT:
  - Strobes held every cycle.
  - div_done returns to RUN, strobes released that cycle.
  - div_start while in DIV_WAIT is ignored.
- FLUSH:
  - hold_if_id = 1 each cycle; the counter decrements and the state returns to RUN at 0.
  - A new jump_req reloads the counter and target.
  - mem_req is not possible (bubbles only).
- jump_en is high for exactly one cycle per accepted jump_req; jump_addr_o holds its last value otherwise.

Test Plan:
- Reset: reset_n = 0 for 3 cycles -> all hold_* = 1, stall_cnt = 0, jump_en = 0. Release -> all strobes 0 with idle inputs.
- Load-use: ex_is_load = 1, ex_rd = 5, id_rs2 = 5, id_rs2_used = 1 -> one cycle of stall_pc = stall_if_id = hold_id_ex = 1, stall_cnt = 1. Same stimulus with ex_rd = 0 -> no stall.
- Jump: jump_req with jump_addr = 0x0000_0100, FLUSH_CYCLES = 3 -> hold_if_id = hold_id_ex = 1 in that cycle, jump_en = 1 with addr 0x100 next cycle, hold_if_id stays high for 2 further cycles, then RUN.
- Memory wait: mem_req = 1 with mem_ack arriving after 4 cycles -> stall_pc high for 4 cycles, released on the ack cycle, stall_cnt = 4. Simultaneous jump_req is not taken until RUN.
- Timeout: MEM_TIMEOUT = 8, mem_ack never asserted -> bus_err pulses once after 8 wait cycles, state returns to RUN, hold_mem_wb = 1 on that cycle.
- Reset during DIV_WAIT: div_start, then reset_n low after 2 cycles -> immediate return to RUN values; div_done afterwards has no effect.

Source files
------------

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: stall/flush controller producing bubble and retain strobes for the 5-stage pipeline
module pipe_hold_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             jump_req,
  input  logic [31:0]      jump_addr,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             div_start,
  input  logic             div_done,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             hold_if_id,
  output logic             hold_id_ex,
  output logic             hold_ex_mem,
  output logic             hold_mem_wb,
  output logic             jump_en,
  output logic [31:0]      jump_addr_o,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [3:0] FL0 = 4'(FLUSH_CYCLES - 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, DIV_WAIT, FLUSH} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [3:0] fl_q, fl_d;
  logic jump_en_q, jump_en_d, bus_err_q, bus_err_d;
  logic [31:0] jump_addr_q, jump_addr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic lu, mem_miss, tmo_hit, jump_take;
  logic s_stall, h_if_id, h_id_ex, h_ex_mem, h_mem_wb;
  assign lu = ex_is_load && ex_rd != 5'd0 &&
              ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
  assign mem_miss = mem_req && !mem_ack;
  assign tmo_inc = tmo_q + 1'b1;
  assign tmo_hit = (MEM_TIMEOUT != 0) && tmo_inc == TW'(MEM_TIMEOUT);
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    fl_d        = fl_q;
    jump_en_d   = 1'b0;
    jump_addr_d = jump_addr_q;
    bus_err_d   = 1'b0;
    jump_take   = 1'b0;
    s_stall     = 1'b0;
    h_if_id     = 1'b0;
    h_id_ex     = 1'b0;
    h_ex_mem    = 1'b0;
    h_mem_wb    = 1'b0;
    case (state_q)
      RUN:
        if (mem_miss) begin
          s_stall  = 1'b1;
          h_mem_wb = 1'b1;
          tmo_d    = '0;
          state_d  = MEM_WAIT;
        end else if (div_start) begin
          s_stall  = 1'b1;
          h_ex_mem = 1'b1;
          state_d  = DIV_WAIT;
        end else if (jump_req) begin
          jump_take = 1'b1;
        end else if (lu) begin
          s_stall = 1'b1;
          h_id_ex = 1'b1;
        end
      MEM_WAIT:
        if (mem_ack) begin
          state_d = RUN;
        end else if (tmo_hit) begin
          // abandoned access still needs its MEM/WB slot bubbled
          h_mem_wb  = 1'b1;
          bus_err_d = 1'b1;
          state_d   = RUN;
        end else begin
          s_stall  = 1'b1;
          h_mem_wb = 1'b1;
          tmo_d    = tmo_inc;
        end
      DIV_WAIT:
        if (div_done) begin
          state_d = RUN;
        end else begin
          s_stall  = 1'b1;
          h_ex_mem = 1'b1;
        end
      FLUSH: begin
        h_if_id = 1'b1;
        if (jump_req) begin
          jump_take = 1'b1;
        end else begin
          fl_d    = fl_q - 4'd1;
          state_d = fl_q == 4'd1 ? RUN : FLUSH;
        end
      end
      default: state_d = RUN;
    endcase
    if (jump_take) begin
      h_if_id     = 1'b1;
      h_id_ex     = 1'b1;
      jump_en_d   = 1'b1;
      jump_addr_d = jump_addr;
      fl_d        = FL0;
      state_d     = FLUSH_CYCLES > 1 ? FLUSH : RUN;
    end
    stall_cnt_d = stall_cnt_q + CNT_W'(s_stall);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      tmo_q       <= '0;
      fl_q        <= '0;
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      fl_q        <= fl_d;
      jump_en_q   <= jump_en_d;
      jump_addr_q <= jump_addr_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  // reset bubbles the whole pipeline and releases every retain
  assign stall_pc    = reset_n && s_stall;
  assign stall_if_id = reset_n && s_stall;
  assign hold_if_id  = !reset_n || h_if_id;
  assign hold_id_ex  = !reset_n || h_id_ex;
  assign hold_ex_mem = !reset_n || h_ex_mem;
  assign hold_mem_wb = !reset_n || h_mem_wb;
  assign jump_en     = jump_en_q;
  assign jump_addr_o = jump_addr_q;
  assign bus_err     = bus_err_q;
  assign stall_cnt   = stall_cnt_q;
endmodule
